// File: rtl/misc_sched_pkg.sv
// Shared definitions for the Misc64X16 unit scheduler: unit opcodes and the
// result-FIFO entry layout.
package misc_sched_pkg;

   localparam logic [2:0] OP_DAA   = 3'b000;
   localparam logic [2:0] OP_DAS   = 3'b001;
   localparam logic [2:0] OP_BSWAP = 3'b010;
   localparam logic [2:0] OP_NEG   = 3'b011;
   localparam logic [2:0] OP_CFZ   = 3'b100;
   localparam logic [2:0] OP_CFN   = 3'b101;
   localparam logic [2:0] OP_POS   = 3'b110;
   localparam logic [2:0] OP_LOOP  = 3'b111;

   // src is sized for the largest supported requester count (8)
   typedef struct packed {
      logic [2:0]   src;
      logic [3:0]   dst;
      logic [2:0]   sr;
      logic [4:0]   flg;
      logic [127:0] data;
   } res_entry_t;

endpackage

// File: rtl/misc_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from the pointer,
// pointer advances past the winner on each grant and holds otherwise.
module misc_rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [NREQ-1:0] req_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = PW'((32'(ptr_q) + i) % NREQ);
         if (en_i && !found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
            ptr_d      = (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/misc_unit_scheduler.sv
// Shares one non-stallable Misc64X16 unit among NREQ requesters; results are
// buffered in a credit-protected FIFO so a stalled consumer never loses data.
module misc_unit_scheduler
   import misc_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int LAT   = 2,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [NREQ-1:0]          REQ,
   output logic [NREQ-1:0]          GNT,
   input  logic [3*NREQ-1:0]        OPi,
   input  logic [3*NREQ-1:0]        SAi,
   input  logic [3*NREQ-1:0]        SDi,
   input  logic [4*NREQ-1:0]        DSTi,
   input  logic [16*NREQ-1:0]       CINi,
   input  logic [128*NREQ-1:0]      Ai,
   output logic                     MACT,
   output logic [2:0]               MOP,
   output logic [2:0]               MSA,
   output logic [2:0]               MSD,
   output logic [15:0]              MCIN,
   output logic [127:0]             MA,
   input  logic [127:0]             MR,
   input  logic [4:0]               MFLG,
   input  logic [2:0]               MSR,
   output logic                     RV,
   input  logic                     RREADY,
   output logic [$clog2(NREQ)-1:0]  RSRC,
   output logic [3:0]               RDST,
   output logic [127:0]             RDATA,
   output logic [4:0]               RFLG,
   output logic [2:0]               RSR
);

   localparam int SW   = $clog2(NREQ);
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW   = $clog2(DEPTH + 1);
   localparam int CW   = $clog2(DEPTH + LAT + 1) + 1;

   logic [NREQ-1:0] gnt;
   logic            grant;
   logic            en;
   logic [CW-1:0]   credits;

   logic [2:0]      sel_op, sel_sa, sel_sd;
   logic [3:0]      sel_dst;
   logic [15:0]     sel_cin;
   logic [127:0]    sel_a;
   logic [SW-1:0]   sel_src;

   logic            mact_q;
   logic [2:0]      mop_q, msa_q, msd_q;
   logic [15:0]     mcin_q;
   logic [127:0]    ma_q;

   logic [LAT-1:0]  vld_q;
   logic [SW-1:0]   src_q [LAT];
   logic [3:0]      dst_q [LAT];

   res_entry_t      mem_q [DEPTH];
   res_entry_t      push_e, head;
   logic [AW-1:0]   wp_q, rp_q;
   logic [NW-1:0]   cnt_q;
   logic            push, pop, rv;

   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Every granted op owns a slot from grant until pop: pipe stages plus FIFO.
   always_comb begin
      credits = CW'(cnt_q);
      for (int unsigned i = 0; i < LAT; i++) credits = credits + CW'(vld_q[i]);
   end

   assign en    = !RESET && (credits < CW'(DEPTH));
   assign grant = |gnt;
   assign GNT   = gnt;

   misc_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk_i (CLK),
      .rst_i (RESET),
      .req_i (REQ),
      .en_i  (en),
      .gnt_o (gnt)
   );

   always_comb begin
      sel_op  = '0;
      sel_sa  = '0;
      sel_sd  = '0;
      sel_dst = '0;
      sel_cin = '0;
      sel_a   = '0;
      sel_src = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_op  = OPi[3*i +: 3];
            sel_sa  = SAi[3*i +: 3];
            sel_sd  = SDi[3*i +: 3];
            sel_dst = DSTi[4*i +: 4];
            sel_cin = CINi[16*i +: 16];
            sel_a   = Ai[128*i +: 128];
            sel_src = SW'(i);
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mact_q <= 1'b0;
         mop_q  <= '0;
         msa_q  <= '0;
         msd_q  <= '0;
         mcin_q <= '0;
         ma_q   <= '0;
      end else begin
         mact_q <= grant;
         if (grant) begin
            mop_q  <= sel_op;
            msa_q  <= sel_sa;
            msd_q  <= sel_sd;
            mcin_q <= sel_cin;
            ma_q   <= sel_a;
         end
      end
   end

   // Stage 0 is loaded alongside the issue register; the last stage lines up with MR.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < LAT; i++) begin
            src_q[i] <= '0;
            dst_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= grant;
         src_q[0] <= sel_src;
         dst_q[0] <= sel_dst;
         for (int unsigned i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            src_q[i] <= src_q[i-1];
            dst_q[i] <= dst_q[i-1];
         end
      end
   end

   assign push = vld_q[LAT-1];
   assign rv   = (cnt_q != '0);
   assign pop  = rv && RREADY;

   always_comb begin
      push_e      = '0;
      push_e.src  = 3'(src_q[LAT-1]);
      push_e.dst  = dst_q[LAT-1];
      push_e.sr   = MSR;
      push_e.flg  = MFLG;
      push_e.data = MR;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            mem_q[wp_q] <= push_e;
            wp_q        <= wrap_inc(wp_q);
         end
         if (pop) rp_q <= wrap_inc(rp_q);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   fifo_no_overflow: assert property (@(posedge CLK) disable iff (RESET)
      !(push && !pop && (cnt_q == NW'(DEPTH))))
      else $error("misc_unit_scheduler: result FIFO overflow");

   assign head  = mem_q[rp_q];
   assign MACT  = mact_q;
   assign MOP   = mop_q;
   assign MSA   = msa_q;
   assign MSD   = msd_q;
   assign MCIN  = mcin_q;
   assign MA    = ma_q;
   assign RV    = rv;
   assign RSRC  = rv ? SW'(head.src) : '0;
   assign RDST  = rv ? head.dst  : '0;
   assign RDATA = rv ? head.data : '0;
   assign RFLG  = rv ? head.flg  : '0;
   assign RSR   = rv ? head.sr   : '0;

endmodule

// File: tb/tb_misc_unit_scheduler.sv
// Scoreboard bench for misc_unit_scheduler with a behavioural Misc64X16 stand-in;
// expected grants and results come from a queue-based model of the sharing rules.
module tb_misc_unit_scheduler;
   import misc_sched_pkg::*;

   localparam int NREQ  = 4;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;

   logic                  CLK = 1'b0;
   logic                  RESET = 1'b1;
   logic [NREQ-1:0]       REQ = '0;
   logic [NREQ-1:0]       GNT;
   logic [3*NREQ-1:0]     OPi = '0, SAi = '0, SDi = '0;
   logic [4*NREQ-1:0]     DSTi = '0;
   logic [16*NREQ-1:0]    CINi = '0;
   logic [128*NREQ-1:0]   Ai = '0;
   logic                  MACT;
   logic [2:0]            MOP, MSA, MSD;
   logic [15:0]           MCIN;
   logic [127:0]          MA;
   logic [127:0]          MR;
   logic [4:0]            MFLG;
   logic [2:0]            MSR;
   logic                  RV;
   logic                  RREADY = 1'b0;
   logic [1:0]            RSRC;
   logic [3:0]            RDST;
   logic [127:0]          RDATA;
   logic [4:0]            RFLG;
   logic [2:0]            RSR;

   misc_unit_scheduler #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RESET(RESET), .REQ(REQ), .GNT(GNT),
      .OPi(OPi), .SAi(SAi), .SDi(SDi), .DSTi(DSTi), .CINi(CINi), .Ai(Ai),
      .MACT(MACT), .MOP(MOP), .MSA(MSA), .MSD(MSD), .MCIN(MCIN), .MA(MA),
      .MR(MR), .MFLG(MFLG), .MSR(MSR),
      .RV(RV), .RREADY(RREADY), .RSRC(RSRC), .RDST(RDST), .RDATA(RDATA),
      .RFLG(RFLG), .RSR(RSR)
   );

   always #5 CLK = ~CLK;

   // Stand-in unit: width 8<<size (128 for size>=4), result size follows SD.
   function automatic logic [135:0] unit_f(input logic [2:0] op, input logic [2:0] sa,
                                           input logic [2:0] sd, input logic [15:0] cin,
                                           input logic [127:0] a);
      int w;
      logic [127:0] mask, am, r;
      logic [4:0] flg;
      w    = (sa >= 3'd4) ? 128 : (8 << sa);
      mask = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
      am   = a & mask;
      r    = '0;
      case (op)
         OP_DAA:   r = am + 128'(cin);
         OP_DAS:   r = am - 128'(cin);
         OP_BSWAP: for (int i = 0; i < w; i++) r[w-1-i] = am[i];
         OP_NEG:   r = -am;
         OP_CFZ:   r = '0;
         OP_CFN:   r = ~am;
         OP_POS:   r = am;
         default:  r = am - 128'd1;
      endcase
      r   = r & mask;
      flg = {1'b0, (op == OP_DAA) && (r < am), 1'b0, r[w-1], r == '0};
      return {sd, flg, r};
   endfunction

   // One internal register stage: sampled on the edge ending the MACT cycle.
   logic [135:0] u_q = '0;
   always @(posedge CLK) if (MACT) u_q <= unit_f(MOP, MSA, MSD, MCIN, MA);
   assign MR   = u_q[127:0];
   assign MFLG = u_q[132:128];
   assign MSR  = u_q[135:133];

   typedef struct {
      int           src;
      logic [3:0]   dst;
      logic [135:0] res;
      int           rdy;
   } exp_t;

   exp_t q[$];
   int checks = 0, errors = 0;
   int cyc = 0, ptr = 0, grants_tot = 0, pops_tot = 0, dut_gnt_cnt = 0;
   bit in_reset = 1'b1, prev_g = 1'b0;
   logic [2:0] prev_op = '0;
   logic       rdy_drv = 1'b0;

   logic [NREQ-1:0] pend = '0;
   logic [2:0]   op_a [NREQ], sa_a [NREQ], sd_a [NREQ];
   logic [3:0]   dst_a [NREQ];
   logic [15:0]  cin_a [NREQ];
   logic [127:0] a_a [NREQ];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [2:0] sa,
                          input logic [2:0] sd, input logic [3:0] dst,
                          input logic [15:0] cin, input logic [127:0] a);
      op_a[i] = op; sa_a[i] = sa; sd_a[i] = sd;
      dst_a[i] = dst; cin_a[i] = cin; a_a[i] = a;
      pend[i] = 1'b1;
   endtask

   task automatic refresh(input logic [NREQ-1:0] mask, input int pct);
      for (int i = 0; i < NREQ; i++)
         if (mask[i] && !pend[i] && $urandom_range(0, 99) < pct)
            set_req(i, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 4)),
                    3'($urandom_range(0, 4)), 4'($urandom), 16'($urandom),
                    {$urandom, $urandom, $urandom, $urandom});
   endtask

   task automatic step(input logic rr);
      int k;
      @(negedge CLK);
      cyc++;
      rdy_drv = rr;
      RREADY  = rr;
      REQ     = pend;
      for (int i = 0; i < NREQ; i++) begin
         OPi[3*i +: 3] = op_a[i];   SAi[3*i +: 3] = sa_a[i];
         SDi[3*i +: 3] = sd_a[i];   DSTi[4*i +: 4] = dst_a[i];
         CINi[16*i +: 16] = cin_a[i]; Ai[128*i +: 128] = a_a[i];
      end
      #1;
      chk("mact", MACT, prev_g);
      if (prev_g) chk("mop", MOP, prev_op);
      k = -1;
      if (grants_tot - pops_tot < DEPTH)
         for (int i = 0; i < NREQ; i++)
            if (k < 0 && pend[(ptr + i) % NREQ]) k = (ptr + i) % NREQ;
      chk("gnt", GNT, (k >= 0) ? (128'd1 << k) : '0);
      if (GNT != '0) dut_gnt_cnt++;
      prev_g = (k >= 0);
      if (k >= 0) begin
         prev_op = op_a[k];
         q.push_back('{k, dst_a[k], unit_f(op_a[k], sa_a[k], sd_a[k], cin_a[k], a_a[k]), cyc + LAT + 1});
         ptr = (k + 1) % NREQ;
         grants_tot++;
         pend[k] = 1'b0;
      end
   endtask

   task automatic do_reset(input bit arm_req);
      @(negedge CLK);
      RESET = 1'b1;
      in_reset = 1'b1;
      if (arm_req) REQ = '1;
      #1;
      chk("rst_gnt", GNT, '0);
      chk("rst_mact", MACT, 1'b0);
      chk("rst_rv", RV, 1'b0);
      chk("rst_rdata", RDATA, '0);
      chk("rst_ma", MA, '0);
      q.delete();
      ptr = 0; grants_tot = 0; pops_tot = 0; pend = '0; prev_g = 1'b0;
      repeat (2) @(negedge CLK);
      REQ = '0;
      RESET = 1'b0;
      in_reset = 1'b0;
   endtask

   task automatic drain();
      pend = '0;
      for (int n = 0; n < 40 && q.size() > 0; n++) step(1'b1);
      chk("drain", 128'(q.size()), '0);
   endtask

   // Monitor: pops the scoreboard whenever the model says the head is consumable.
   initial begin
      bit exp_rv;
      forever begin
         @(negedge CLK);
         #2;
         if (!in_reset) begin
            exp_rv = (q.size() > 0) && (q[0].rdy <= cyc);
            chk("rv", RV, exp_rv);
            if (exp_rv && RV) begin
               chk("rsrc", RSRC, 128'(q[0].src));
               chk("rdst", RDST, q[0].dst);
               chk("rdata", RDATA, q[0].res[127:0]);
               chk("rflg", RFLG, q[0].res[132:128]);
               chk("rsr", RSR, q[0].res[135:133]);
            end
            if (exp_rv && rdy_drv) begin
               void'(q.pop_front());
               pops_tot++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < NREQ; i++) set_req(i, '0, '0, '0, '0, '0, '0);
      pend = '0;
      do_reset(1'b1);

      // Single BSWAP from requester 0: visible at grant+3.
      set_req(0, OP_BSWAP, 3'b000, 3'b000, 4'h0, 16'h0, 128'h01);
      step(1'b1);
      repeat (3) step(1'b1);
      chk("bswap_rv", RV, 1'b1);
      chk("bswap_data", RDATA, 128'h80);
      chk("bswap_sign", RFLG[1], 1'b1);
      chk("bswap_src", RSRC, 2'd0);
      drain();

      // NEG 64-bit from requester 2.
      set_req(2, OP_NEG, 3'b011, 3'b011, 4'hA, 16'h0, 128'd5);
      step(1'b1);
      repeat (3) step(1'b1);
      chk("neg_data", RDATA, 128'hFFFF_FFFF_FFFF_FFFB);
      chk("neg_dst", RDST, 4'hA);
      chk("neg_src", RSRC, 2'd2);
      drain();

      // All requesters held with consumer ready: one grant per cycle, rotating.
      dut_gnt_cnt = 0;
      for (int n = 0; n < 8; n++) begin
         refresh('1, 100);
         step(1'b1);
      end
      chk("rr_grants", 128'(dut_gnt_cnt), 128'd8);
      drain();

      // Stalled consumer: credits cap grants at DEPTH.
      dut_gnt_cnt = 0;
      for (int n = 0; n < 10; n++) begin
         refresh(4'b0010, 100);
         step(1'b0);
      end
      chk("depth_grants", 128'(dut_gnt_cnt), 128'(DEPTH));
      refresh(4'b0010, 100);
      step(1'b1);
      refresh(4'b0010, 100);
      step(1'b0);
      chk("regrant", GNT, 4'b0010);
      for (int n = 0; n < 3; n++) begin
         refresh(4'b0010, 100);
         step(1'b0);
      end

      // Full FIFO released with requests pending: push and pop coexist.
      for (int n = 0; n < 20; n++) begin
         refresh('1, 100);
         step(1'b1);
      end
      drain();

      // Randomized traffic and back-pressure.
      for (int n = 0; n < 400; n++) begin
         refresh('1, 40);
         step($urandom_range(0, 3) != 0);
      end
      drain();

      // Reset with two results buffered and two in flight.
      for (int n = 0; n < 4; n++) begin
         refresh('1, 100);
         step(1'b0);
      end
      do_reset(1'b0);
      for (int n = 0; n < 6; n++) step(1'b1);
      for (int n = 0; n < 60; n++) begin
         refresh('1, 50);
         step($urandom_range(0, 1) != 0);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
